fanout_fork_buffer: RTL and testbench
=====================================

# fanout_fork_buffer

Registered eager-fork stage that sends one source stream to up to NUM_OUT destination streams on the CGRA interconnect. Each accepted word is held in a one-entry buffer. The buffer presents the word to every enabled destination independently and retires it only after every enabled destination has completed its own valid/ready handshake. This is the transmit/valid side of the fanout ready-aggregation logic: instead of requiring all sinks to be ready in the same cycle, it tracks per-sink completion. It sits between a tile's output port and the switch-box fanout.

## Interface
Parameters:
- NUM_OUT, 4: number of destination streams (1..32)
- DATA_W, 16: payload width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of buffer and counter
- cfg_en  in  NUM_OUT  per-destination enable mask (configuration)
- in_data  in  DATA_W  source payload
- in_valid  in  1  source valid
- in_ready  out  1  source ready
- out_data  out  DATA_W  buffered payload, shared by all destinations
- out_valid  out  NUM_OUT  per-destination valid
- out_ready  in  NUM_OUT  per-destination ready
- xfer_cnt  out  16  count of fully retired words

## Operation
State:
- full: 1 bit
- data_q: DATA_W
- pend: NUM_OUT mask of destinations still owed the word
- xfer_cnt: 16-bit counter

Definitions:
- hs[i] = out_valid[i] & out_ready[i]
- out_valid[i] = full & pend[i]
- out_data = data_q
- last = full & ((pend & ~out_ready) == 0), i.e. every still-pending destination handshakes this cycle
- in_ready = ~full | last
- accept = in_valid & in_ready

Each cycle, in priority order:
- clr: full, pend and xfer_cnt go to 0, and data_q goes to 0. Any accept in the same cycle is dropped.
- accept with cfg_en != 0:
  - data_q <= in_data
  - pend <= cfg_en
  - full <= 1
  - If last also holds, xfer_cnt increments for the retiring word.
- accept with cfg_en == 0: the word is discarded. full and pend are unchanged (they are 0, or cleared by last), and xfer_cnt is not incremented.
- no accept:
  - pend <= pend & ~hs
  - If last holds, full <= 0 and xfer_cnt increments (wrapping 0xFFFF -> 0).

Mask and counter rules:
- cfg_en is sampled only at accept. Changes while full do not affect the word in flight.
- A destination that has handshaken drops out_valid the next cycle, even if the other destinations are still stalled.
- Order is preserved: a new word is never visible before the previous one has fully retired.

## Timing
- Reset values (asynchronous on rst_n low):
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - xfer_cnt = 0
  - full = 0, pend = 0
- Latency: a word accepted at edge k drives out_valid at cycle k+1 (one-cycle latency).
- Throughput: one word per cycle when all enabled destinations are continuously ready. last and accept in the same cycle allow back-to-back transfers.
- Combinational paths:
  - out_ready -> in_ready (through last)
  - There is no path from in_valid to out_valid.
- Reset asserted mid-transfer: the word is lost, all outputs return to reset values immediately, and the block resumes with in_ready = 1 after rst_n is released.
- out_valid[i] must not deassert before hs[i] occurs, except on clr or reset.

## Test plan
With NUM_OUT=4 and DATA_W=16 unless noted:
- **Basic fork:** cfg_en=4'b1111, send 0xA5A5, out_ready=1111 held.
  - out_valid=1111 for one cycle with out_data=0xA5A5; in_ready stays 1; xfer_cnt=1.
- **Staggered sinks:** cfg_en=1011, send 0x1234. out_ready[0] high at cycle 1, [1] at cycle 3, [3] at cycle 5.
  - out_valid evolves 1011 -> 1010 -> 1000 -> 0000.
  - in_ready is 0 during cycles 1-4 and 1 at cycle 5.
  - out_valid[2] is never asserted; xfer_cnt=1.
- **Back-to-back:** cfg_en=0011, all ready, stream 0x0001..0x0008 with in_valid high.
  - 8 words delivered on consecutive cycles, in order; xfer_cnt=8.
- **Mask change in flight:** word 0x00FF accepted with cfg_en=0001; sink 0 stalls; cfg_en switches to 1110 before the handshake.
  - Only out_valid[0] is asserted until its handshake.
  - The next word goes to sinks 1-3.
- **Empty mask and clear:**
  - cfg_en=0000, send 0xBEEF: word accepted and discarded, out_valid=0, xfer_cnt unchanged.
  - With a stalled word pending, assert clr: out_valid=0 and in_ready=1 next cycle, xfer_cnt=0.
- **Counter wrap and async reset:**
  - Preload 0xFFFF retirements, complete one more: xfer_cnt=0x0000.
  - Assert rst_n low mid-transfer: outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fanout_fork_buffer.sv
// fanout_fork_buffer
//   Registered eager-fork stage. One source stream is held in a one-entry
//   buffer and offered to up to NUM_OUT destinations independently. The word
//   retires only once every destination enabled at accept time has completed
//   its own valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous clear of buffer, pending mask and counter
//   cfg_en[NUM_OUT]   per-destination enable, sampled only when a word is accepted
//   in_data/valid/ready  source stream
//   out_data          buffered payload, shared by all destinations
//   out_valid/ready   per-destination handshake
//   xfer_cnt          16-bit wrapping count of fully retired words

// Per-destination pending bit. Loads the enable at accept and clears on this
// destination's handshake, so a served sink drops valid while others stall.
module fanout_fork_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic en,
    input  logic full,
    input  logic out_ready,
    output logic out_valid,
    output logic pend
);
    logic pend_d, pend_q;

    assign out_valid = full & pend_q;
    assign pend      = pend_q;

    always_comb begin
        pend_d = pend_q;
        if (clr)                         pend_d = 1'b0;
        else if (load)                   pend_d = en;
        else if (out_valid && out_ready) pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= 1'b0;
        else        pend_q <= pend_d;
    end
endmodule

module fanout_fork_buffer #(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [NUM_OUT-1:0] cfg_en,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [15:0]        xfer_cnt
);
    logic               full_d, full_q;
    logic [DATA_W-1:0]  data_d, data_q;
    logic [15:0]        cnt_d, cnt_q;
    logic [NUM_OUT-1:0] pend;
    logic               last, accept, load;

    // Every still-pending destination handshakes this cycle.
    assign last     = full_q & ((pend & ~out_ready) == '0);
    // Retirement and acceptance may share a cycle for full throughput.
    assign in_ready = ~full_q | last;
    assign accept   = in_valid & in_ready;
    // An empty mask discards the word: nothing is loaded.
    assign load     = accept & (cfg_en != '0) & ~clr;

    assign out_data = data_q;
    assign xfer_cnt = cnt_q;

    fanout_fork_lane u_lane [NUM_OUT-1:0] (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .en        (cfg_en),
        .full      (full_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .pend      (pend)
    );

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr) begin
            full_d = 1'b0;
            data_d = '0;
            cnt_d  = '0;
        end else begin
            if (last) begin
                full_d = 1'b0;
                cnt_d  = cnt_q + 16'd1;
            end
            if (load) begin
                full_d = 1'b1;
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fanout_fork_buffer.sv
module tb_fanout_fork_buffer;
    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic [3:0]  cfg_en;
    logic [15:0] in_data;
    logic        in_valid, in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_valid, out_ready;
    logic [15:0] xfer_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fanout_fork_buffer #(.NUM_OUT(4), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_en(cfg_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1ns after it, checks follow a further 1ns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; cfg_en = 4'b0; in_data = 16'h0;
        in_valid = 1'b0; out_ready = 4'b0;
        #12;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst xfer_cnt", xfer_cnt, 0);
        rst_n = 1'b1;
        step();

        // Basic fork
        cfg_en = 4'b1111; out_ready = 4'b1111; in_data = 16'hA5A5; in_valid = 1'b1;
        #1 chk("basic in_ready0", in_ready, 1);
        step(); in_valid = 1'b0; #1;
        chk("basic out_valid", out_valid, 4'b1111);
        chk("basic out_data", out_data, 16'hA5A5);
        chk("basic in_ready1", in_ready, 1);
        step(); #1;
        chk("basic out_valid_off", out_valid, 0);
        chk("basic xfer_cnt", xfer_cnt, 1);

        // Staggered sinks
        cfg_en = 4'b1011; out_ready = 4'b0000; in_data = 16'h1234; in_valid = 1'b1;
        step(); in_valid = 1'b0; out_ready = 4'b0001; #1;      // cycle 1
        chk("stag c1 valid", out_valid, 4'b1011);
        chk("stag c1 in_ready", in_ready, 0);
        step(); out_ready = 4'b0000; #1;                        // cycle 2
        chk("stag c2 valid", out_valid, 4'b1010);
        chk("stag c2 in_ready", in_ready, 0);
        step(); out_ready = 4'b0010; #1;                        // cycle 3
        chk("stag c3 valid", out_valid, 4'b1010);
        chk("stag c3 in_ready", in_ready, 0);
        step(); out_ready = 4'b0000; #1;                        // cycle 4
        chk("stag c4 valid", out_valid, 4'b1000);
        chk("stag c4 in_ready", in_ready, 0);
        step(); out_ready = 4'b1000; #1;                        // cycle 5
        chk("stag c5 valid", out_valid, 4'b1000);
        chk("stag c5 in_ready", in_ready, 1);
        step(); out_ready = 4'b0000; #1;
        chk("stag done valid", out_valid, 0);
        chk("stag xfer_cnt", xfer_cnt, 2);

        // Back-to-back
        cfg_en = 4'b0011; out_ready = 4'b1111; in_valid = 1'b1; in_data = 16'd1;
        step();
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) in_data = 16'(i + 1); else in_valid = 1'b0;
            #1;
            chk("b2b data", out_data, i);
            chk("b2b valid", out_valid, 4'b0011);
            chk("b2b in_ready", in_ready, 1);
            step();
        end
        #1;
        chk("b2b idle", out_valid, 0);
        chk("b2b xfer_cnt", xfer_cnt, 10);

        // Mask change in flight
        cfg_en = 4'b0001; out_ready = 4'b0000; in_data = 16'h00FF; in_valid = 1'b1;
        step(); in_valid = 1'b0; cfg_en = 4'b1110; #1;
        chk("mask hold valid0", out_valid, 4'b0001);
        chk("mask hold in_ready", in_ready, 0);
        step(); #1;
        chk("mask hold valid1", out_valid, 4'b0001);
        chk("mask hold data", out_data, 16'h00FF);
        out_ready = 4'b1111; in_valid = 1'b1; in_data = 16'h0102; #1;
        chk("mask last in_ready", in_ready, 1);
        step(); in_valid = 1'b0; #1;
        chk("mask next valid", out_valid, 4'b1110);
        chk("mask next data", out_data, 16'h0102);
        chk("mask cnt", xfer_cnt, 11);
        step(); #1;
        chk("mask done valid", out_valid, 0);
        chk("mask done cnt", xfer_cnt, 12);

        // Empty mask: accepted and discarded
        cfg_en = 4'b0000; in_data = 16'hBEEF; in_valid = 1'b1; #1;
        chk("empty in_ready", in_ready, 1);
        step(); in_valid = 1'b0; #1;
        chk("empty valid", out_valid, 0);
        chk("empty cnt", xfer_cnt, 12);
        chk("empty data kept", out_data, 16'h0102);

        // Clear with a stalled word
        cfg_en = 4'b1111; out_ready = 4'b0000; in_data = 16'h5555; in_valid = 1'b1;
        step(); in_valid = 1'b0; #1;
        chk("clr pre valid", out_valid, 4'b1111);
        chk("clr pre in_ready", in_ready, 0);
        clr = 1'b1;
        step(); clr = 1'b0; #1;
        chk("clr valid", out_valid, 0);
        chk("clr in_ready", in_ready, 1);
        chk("clr cnt", xfer_cnt, 0);
        chk("clr data", out_data, 0);

        // Counter wrap: 65535 retirements, then one more
        cfg_en = 4'b0001; out_ready = 4'b1111; in_data = 16'h0042; in_valid = 1'b1;
        repeat (65535) step();
        in_valid = 1'b0;
        step(); #1;
        chk("wrap ffff", xfer_cnt, 16'hFFFF);
        in_valid = 1'b1;
        step(); in_valid = 1'b0;
        step(); #1;
        chk("wrap zero", xfer_cnt, 16'h0000);

        // Asynchronous reset mid-transfer
        cfg_en = 4'b1111; out_ready = 4'b0000; in_data = 16'h7777; in_valid = 1'b1;
        step(); in_valid = 1'b0; #1;
        chk("arst pre valid", out_valid, 4'b1111);
        chk("arst pre data", out_data, 16'h7777);
        #1 rst_n = 1'b0;
        #1;
        chk("arst valid", out_valid, 0);
        chk("arst data", out_data, 0);
        chk("arst in_ready", in_ready, 1);
        chk("arst cnt", xfer_cnt, 0);
        rst_n = 1'b1;
        step(); #1;
        chk("arst resume in_ready", in_ready, 1);
        chk("arst resume valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
